// File: rtl/calc1.sv
// calc1: four-port unsigned integer calculator, one private datapath per port.
// Ports: c_clk, reset[1:7] (sync, any bit high resets), reqN_cmd_in[0:3],
// reqN_data_in[0:31], out_respN[0:1], out_dataN[0:31] for N = 1..4.

// calc1_lane: one requester's command/operand capture, ALU and output delay.
// Ports: clk, rst, cmd_in, data_in in; resp, data out (registered).
module calc1_lane (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:3]  cmd_in,
    input  logic [0:31] data_in,
    output logic [0:1]  resp,
    output logic [0:31] data
);

    typedef enum logic {
        S_CMD,
        S_OPND
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [0:3]  cmd_q;
    logic [0:31] op1_q;
    logic [0:32] sum;
    logic [0:1]  res_resp;
    logic [0:31] res_data;

    // Three stages between the operand edge and the output register.
    logic [0:1]  resp_p [0:2];
    logic [0:31] data_p [0:2];

    always_comb begin
        state_nxt = state;
        res_resp  = 2'd0;
        res_data  = 32'd0;
        sum       = {1'b0, op1_q} + {1'b0, data_in};
        unique case (state)
            S_CMD: begin
                if (cmd_in != 4'd0)
                    state_nxt = S_OPND;
            end
            S_OPND: begin
                // cmd_in is ignored here: this cycle only carries op2.
                state_nxt = S_CMD;
                case (cmd_q)
                    4'd1: begin
                        if (sum[0]) begin
                            res_resp = 2'd2;
                        end else begin
                            res_resp = 2'd1;
                            res_data = sum[1:32];
                        end
                    end
                    4'd2: begin
                        if (data_in > op1_q) begin
                            res_resp = 2'd2;
                        end else begin
                            res_resp = 2'd1;
                            res_data = op1_q - data_in;
                        end
                    end
                    4'd5: begin
                        res_resp = 2'd1;
                        res_data = op1_q << data_in[27:31];
                    end
                    4'd6: begin
                        res_resp = 2'd1;
                        res_data = op1_q >> data_in[27:31];
                    end
                    default: begin
                        res_resp = 2'd2;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CMD;
            cmd_q     <= 4'd0;
            op1_q     <= 32'd0;
            resp_p[0] <= 2'd0;
            resp_p[1] <= 2'd0;
            resp_p[2] <= 2'd0;
            data_p[0] <= 32'd0;
            data_p[1] <= 32'd0;
            data_p[2] <= 32'd0;
            resp      <= 2'd0;
            data      <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == S_CMD && cmd_in != 4'd0) begin
                cmd_q <= cmd_in;
                op1_q <= data_in;
            end
            resp_p[0] <= res_resp;
            data_p[0] <= res_data;
            resp_p[1] <= resp_p[0];
            data_p[1] <= data_p[0];
            resp_p[2] <= resp_p[1];
            data_p[2] <= data_p[1];
            resp      <= resp_p[2];
            data      <= data_p[2];
        end
    end

endmodule

module calc1 (
    input  logic        c_clk,
    input  logic [1:7]  reset,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:31] req4_data_in,
    output logic [0:1]  out_resp1,
    output logic [0:1]  out_resp2,
    output logic [0:1]  out_resp3,
    output logic [0:1]  out_resp4,
    output logic [0:31] out_data1,
    output logic [0:31] out_data2,
    output logic [0:31] out_data3,
    output logic [0:31] out_data4
);

    logic rst;

    assign rst = |reset;

    calc1_lane u_lane1 (
        .clk    (c_clk),
        .rst    (rst),
        .cmd_in (req1_cmd_in),
        .data_in(req1_data_in),
        .resp   (out_resp1),
        .data   (out_data1)
    );

    calc1_lane u_lane2 (
        .clk    (c_clk),
        .rst    (rst),
        .cmd_in (req2_cmd_in),
        .data_in(req2_data_in),
        .resp   (out_resp2),
        .data   (out_data2)
    );

    calc1_lane u_lane3 (
        .clk    (c_clk),
        .rst    (rst),
        .cmd_in (req3_cmd_in),
        .data_in(req3_data_in),
        .resp   (out_resp3),
        .data   (out_data3)
    );

    calc1_lane u_lane4 (
        .clk    (c_clk),
        .rst    (rst),
        .cmd_in (req4_cmd_in),
        .data_in(req4_data_in),
        .resp   (out_resp4),
        .data   (out_data4)
    );

endmodule

// File: tb/tb_calc1.sv
// tb_calc1: self-checking bench for calc1.
// Directed cases plus random traffic against a per-port scheduled model.
module tb_calc1;

    logic        c_clk = 1'b0;
    logic [1:7]  reset;
    logic [0:3]  cmd  [4];
    logic [0:31] din  [4];
    logic [0:1]  resp [4];
    logic [0:31] dout [4];

    int checks = 0;
    int fails  = 0;
    int edge_n = 0;

    bit          pend  [4];
    logic [3:0]  pcmd  [4];
    logic [31:0] pop1  [4];
    logic [1:0]  er    [4][8];
    logic [31:0] ed    [4][8];

    always #5 c_clk = ~c_clk;

    calc1 dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req1_cmd_in (cmd[0]),
        .req2_cmd_in (cmd[1]),
        .req3_cmd_in (cmd[2]),
        .req4_cmd_in (cmd[3]),
        .req1_data_in(din[0]),
        .req2_data_in(din[1]),
        .req3_data_in(din[2]),
        .req4_data_in(din[3]),
        .out_resp1   (resp[0]),
        .out_resp2   (resp[1]),
        .out_resp3   (resp[2]),
        .out_resp4   (resp[3]),
        .out_data1   (dout[0]),
        .out_data2   (dout[1]),
        .out_data3   (dout[2]),
        .out_data4   (dout[3])
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)",
                     tag, got, exp, edge_n);
        end
    endtask

    // Result of one command from the arithmetic rules: {resp, data}.
    function automatic logic [33:0] ref_op(input logic [3:0] c,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint unsigned s;
        logic [31:0] t;
        case (c)
            4'd1: begin
                s = 64'(a) + 64'(b);
                if (s > 64'hFFFF_FFFF) return {2'd2, 32'd0};
                return {2'd1, s[31:0]};
            end
            4'd2: begin
                if (b > a) return {2'd2, 32'd0};
                t = a - b;
                return {2'd1, t};
            end
            4'd5: begin
                t = a << (b % 32);
                return {2'd1, t};
            end
            4'd6: begin
                t = a >> (b % 32);
                return {2'd1, t};
            end
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    // One clock: advance the model with the inputs seen at this edge,
    // then compare every port against what the model says is due now.
    task automatic step();
        logic [1:0]  xr [4];
        logic [31:0] xd [4];
        logic [33:0] r;
        int          slot;
        @(posedge c_clk);
        edge_n++;
        slot = edge_n % 8;
        for (int p = 0; p < 4; p++) begin
            if (reset != 7'd0) begin
                pend[p] = 1'b0;
                for (int s = 0; s < 8; s++) begin
                    er[p][s] = 2'd0;
                    ed[p][s] = 32'd0;
                end
            end else if (pend[p]) begin
                r = ref_op(pcmd[p], pop1[p], din[p]);
                er[p][(edge_n + 3) % 8] = r[33:32];
                ed[p][(edge_n + 3) % 8] = r[31:0];
                pend[p] = 1'b0;
            end else if (cmd[p] != 4'd0) begin
                pend[p] = 1'b1;
                pcmd[p] = cmd[p];
                pop1[p] = din[p];
            end
            xr[p] = er[p][slot];
            xd[p] = ed[p][slot];
            er[p][slot] = 2'd0;
            ed[p][slot] = 32'd0;
        end
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("p%0d_resp", p + 1), 64'(resp[p]), 64'(xr[p]));
            chk($sformatf("p%0d_data", p + 1), 64'(dout[p]), 64'(xd[p]));
        end
    endtask

    task automatic idle_all();
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0;
            din[p] = 32'd0;
        end
    endtask

    // Single command on port p; opc is driven during the operand cycle.
    task automatic do_op(input int p, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] opc, input string tag,
                         input logic [1:0] xr, input logic [31:0] xd);
        cmd[p] = c;
        din[p] = a;
        step();
        cmd[p] = opc;
        din[p] = b;
        step();
        cmd[p] = 4'd0;
        din[p] = 32'd0;
        step();
        step();
        step();
        chk({tag, "_r"}, 64'(resp[p]), 64'(xr));
        chk({tag, "_d"}, 64'(dout[p]), 64'(xd));
        step();
    endtask

    function automatic logic [31:0] rnd_data();
        case ($urandom % 4)
            0: return 32'($urandom % 40);
            1: return 32'hFFFF_FFFF - 32'($urandom % 40);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [3:0] ctab [8];
        ctab = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd0, 4'd3, 4'd0};
        for (int p = 0; p < 4; p++) begin
            pend[p] = 1'b0;
            pcmd[p] = 4'd0;
            pop1[p] = 32'd0;
            for (int s = 0; s < 8; s++) begin
                er[p][s] = 2'd0;
                ed[p][s] = 32'd0;
            end
        end

        // Reset held with random inputs: outputs stay zero.
        reset = 7'h40;
        repeat (4) begin
            for (int p = 0; p < 4; p++) begin
                cmd[p] = 4'($urandom);
                din[p] = 32'($urandom);
            end
            step();
        end
        chk("rst_resp1", 64'(resp[0]), 64'd0);
        chk("rst_data1", 64'(dout[0]), 64'd0);
        reset = 7'd0;
        idle_all();
        step();

        // Reset on the operand edge discards the command.
        cmd[0] = 4'd1;
        din[0] = 32'd5;
        step();
        cmd[0] = 4'd0;
        din[0] = 32'd3;
        reset = 7'h40;
        step();
        reset = 7'd0;
        din[0] = 32'd0;
        step();
        step();
        step();
        chk("rst_drop_r", 64'(resp[0]), 64'd0);
        step();

        do_op(0, 4'd1, 32'h1, 32'h1FFF_FFFF, 4'd0, "add1", 2'd1, 32'h2000_0000);
        do_op(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 4'd0, "add2",
              2'd1, 32'h3FFF_FFFE);
        do_op(0, 4'd1, 32'h0, 32'h0, 4'd0, "add0", 2'd1, 32'h0);
        do_op(0, 4'd1, 32'hFFFF_FFFF, 32'h1, 4'd0, "addov", 2'd2, 32'h0);
        do_op(0, 4'd2, 32'h0F, 32'h01, 4'd0, "sub1", 2'd1, 32'h0E);
        do_op(0, 4'd2, 32'h01, 32'h0F, 4'd0, "subun", 2'd2, 32'h0);
        do_op(0, 4'd2, 32'h7, 32'h7, 4'd0, "subeq", 2'd1, 32'h0);
        do_op(0, 4'd5, 32'h1, 32'd31, 4'd0, "shl31", 2'd1, 32'h8000_0000);
        do_op(0, 4'd6, 32'h8000_0000, 32'h23, 4'd0, "shr3", 2'd1, 32'h1000_0000);
        do_op(0, 4'd3, 32'h1234, 32'h5678, 4'd0, "inv3", 2'd2, 32'h0);
        do_op(0, 4'd4, 32'h9, 32'h1, 4'd0, "inv4", 2'd2, 32'h0);
        do_op(0, 4'd1, 32'h10, 32'h20, 4'd5, "opcign", 2'd1, 32'h30);
        do_op(3, 4'd15, 32'h1, 32'h1, 4'd0, "inv15", 2'd2, 32'h0);

        // All four ports in the same cycle.
        cmd = '{4'd1, 4'd2, 4'd5, 4'd4};
        din = '{32'd1, 32'd2, 32'd1, 32'd7};
        step();
        idle_all();
        din = '{32'd2, 32'd5, 32'd4, 32'd9};
        step();
        idle_all();
        step();
        step();
        step();
        chk("cc1_r", 64'(resp[0]), 64'd1);
        chk("cc1_d", 64'(dout[0]), 64'd3);
        chk("cc2_r", 64'(resp[1]), 64'd2);
        chk("cc2_d", 64'(dout[1]), 64'd0);
        chk("cc3_r", 64'(resp[2]), 64'd1);
        chk("cc3_d", 64'(dout[2]), 64'd16);
        chk("cc4_r", 64'(resp[3]), 64'd2);
        chk("cc4_d", 64'(dout[3]), 64'd0);
        step();

        // Back-to-back adds on port 2.
        cmd[1] = 4'd1; din[1] = 32'd1; step();
        cmd[1] = 4'd0; din[1] = 32'd1; step();
        cmd[1] = 4'd1; din[1] = 32'd2; step();
        cmd[1] = 4'd0; din[1] = 32'd2; step();
        din[1] = 32'd0;
        step();
        chk("b2b_e4_r", 64'(resp[1]), 64'd1);
        chk("b2b_e4_d", 64'(dout[1]), 64'd2);
        step();
        chk("b2b_e5_r", 64'(resp[1]), 64'd0);
        step();
        chk("b2b_e6_r", 64'(resp[1]), 64'd1);
        chk("b2b_e6_d", 64'(dout[1]), 64'd4);
        step();

        // Random traffic, including stray operand-cycle cmds and short resets.
        repeat (800) begin
            for (int p = 0; p < 4; p++) begin
                if ($urandom % 6 == 0)
                    cmd[p] = 4'($urandom);
                else
                    cmd[p] = ctab[$urandom % 8];
                din[p] = rnd_data();
            end
            if ($urandom % 60 == 0)
                reset = 7'(1 << ($urandom % 7));
            else
                reset = 7'd0;
            step();
        end
        reset = 7'd0;
        idle_all();
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
